fpu_issue_ctrl: RTL and testbench

- Initiator side of the floating-point ALU operand interface.
- Accepts one decoded FP instruction at a time from decode/regfile over a valid/ready handshake.
- Drives and holds operands and controls toward the registered FP ALU for the op's latency.
- Captures the ALU result and presents it to FP writeback over a second valid/ready handshake.

---
 rtl/fp_pkg.sv | 36 +++
 rtl/fpu_lat_counter.sv | 29 ++
 rtl/fpu_issue_ctrl.sv | 156 +++++++++++++++
 tb/tb_fpu_issue_ctrl.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared definitions for the FP issue path: op-class codes, controller
// state encoding and small op-class helpers.
// Optional feature macro: FALU_DIV_EN (makes op class 3'b010, divide, legal).
package fp_pkg;

  localparam logic [2:0] FOP_ADDSUB = 3'b000;
  localparam logic [2:0] FOP_MUL    = 3'b001;
  localparam logic [2:0] FOP_DIV    = 3'b010;
  localparam logic [2:0] FOP_CMP    = 3'b011;
  localparam logic [2:0] FOP_CVT    = 3'b100;
  localparam logic [2:0] FOP_NONE   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    WB   = 2'b10
  } fp_state_e;

  // An op class is legal when the ALU actually implements it in this build.
  function automatic logic op_is_legal(input logic [2:0] ctrl);
    case (ctrl)
      FOP_ADDSUB, FOP_MUL, FOP_CMP, FOP_CVT: return 1'b1;
`ifdef FALU_DIV_EN
      FOP_DIV: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

  // Only multiply and divide can legitimately overflow; the ALU flag is
  // ignored for every other class.
  function automatic logic ovf_forwarded(input logic [2:0] ctrl);
    return (ctrl == FOP_MUL) || (ctrl == FOP_DIV);
  endfunction

endpackage

// File: rtl/fpu_lat_counter.sv
// Loadable down-counter that tracks the remaining ALU latency of the
// in-flight op. done is high whenever the count has reached zero.
module fpu_lat_counter #(
  parameter int W = 5
) (
  input  logic         CLK,
  input  logic         rst,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt;

  // Load takes priority; otherwise count down while enabled, saturating at 0.
  always_ff @(posedge CLK) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/fpu_issue_ctrl.sv
// Initiator side of the FP ALU operand interface: accepts one decoded FP
// instruction, holds its operands toward the registered ALU for the op's
// latency, captures the result and offers it to FP writeback.
// Optional feature macro: FALU_DIV_EN (divide support with DIV_LAT latency).
module fpu_issue_ctrl
  import fp_pkg::*;
#(
  parameter int FLEN     = 32,
  parameter int REG_ADDR = 5,
  parameter int ALU_LAT  = 1,
  parameter int DIV_LAT  = 16
) (
  input  logic                CLK,
  input  logic                rst,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [2:0]          in_ctrl,
  input  logic [2:0]          in_funct3,
  input  logic [1:0]          in_funct7_3_2,
  input  logic [REG_ADDR-1:0] in_rd,
  input  logic [FLEN-1:0]     in_rs1,
  input  logic [FLEN-1:0]     in_rs2,
  output logic [FLEN-1:0]     alu_rs1,
  output logic [FLEN-1:0]     alu_rs2,
  output logic [2:0]          alu_ctrl,
  output logic [2:0]          alu_funct3,
  output logic [1:0]          alu_funct7_3_2,
  input  logic [FLEN-1:0]     alu_result,
  input  logic                alu_overflow,
  output logic                wb_valid,
  input  logic                wb_ready,
  output logic [REG_ADDR-1:0] wb_rd,
  output logic [FLEN-1:0]     wb_data,
  output logic                wb_overflow,
  output logic                wb_illegal,
  output logic                busy
);

  localparam int MAX_LAT = (ALU_LAT > DIV_LAT) ? ALU_LAT : DIV_LAT;
  localparam int CW      = $clog2(MAX_LAT + 1);

  // A zero-latency ALU cannot be driven by this controller.
  generate
    if (ALU_LAT < 1) begin : g_lat_check
      $error("fpu_issue_ctrl: ALU_LAT must be at least 1");
    end
  endgenerate

  fp_state_e     state_q, state_d;
  logic          accept;
  logic          in_legal;
  logic          capture;
  logic          wb_fire;
  logic          cnt_done;
  logic [CW-1:0] load_val;

  assign in_ready = (state_q == IDLE) && !flush;
  assign busy     = (state_q != IDLE);

`ifdef FALU_DIV_EN
  assign load_val = (in_ctrl == FOP_DIV) ? CW'(DIV_LAT) : CW'(ALU_LAT);
`else
  assign load_val = CW'(ALU_LAT);
`endif

  fpu_lat_counter #(.W(CW)) u_lat_counter (
    .CLK      (CLK),
    .rst      (rst),
    .load     (accept && in_legal),
    .en       (state_q == EXEC),
    .load_val (load_val),
    .done     (cnt_done)
  );

  // State register.
  always_ff @(posedge CLK) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state and per-cycle strobes; flush overrides every transition.
  always_comb begin
    state_d  = state_q;
    accept   = in_valid && in_ready;
    in_legal = op_is_legal(in_ctrl);
    capture  = 1'b0;
    wb_fire  = 1'b0;
    case (state_q)
      IDLE: if (accept) state_d = in_legal ? EXEC : WB;
      EXEC: if (cnt_done) begin
        capture = 1'b1;
        state_d = WB;
      end
      WB: if (wb_valid && wb_ready) begin
        wb_fire = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d = IDLE;
      capture = 1'b0;
      wb_fire = 1'b0;
    end
  end

  // Operand hold registers toward the ALU and the writeback result registers.
  // An illegal op skips the ALU entirely and raises wb_valid one cycle later.
  always_ff @(posedge CLK) begin
    if (rst) begin
      alu_rs1        <= '0;
      alu_rs2        <= '0;
      alu_ctrl       <= FOP_NONE;
      alu_funct3     <= '0;
      alu_funct7_3_2 <= '0;
      wb_valid       <= 1'b0;
      wb_rd          <= '0;
      wb_data        <= '0;
      wb_overflow    <= 1'b0;
      wb_illegal     <= 1'b0;
    end else if (flush) begin
      wb_valid <= 1'b0;
      alu_ctrl <= FOP_NONE;
    end else begin
      if (accept) begin
        wb_rd <= in_rd;
        if (in_legal) begin
          alu_rs1        <= in_rs1;
          alu_rs2        <= in_rs2;
          alu_ctrl       <= in_ctrl;
          alu_funct3     <= in_funct3;
          alu_funct7_3_2 <= in_funct7_3_2;
        end else begin
          wb_illegal  <= 1'b1;
          wb_data     <= '0;
          wb_overflow <= 1'b0;
        end
      end
      if (capture) begin
        wb_data     <= alu_result;
        wb_overflow <= alu_overflow && ovf_forwarded(alu_ctrl);
        wb_illegal  <= 1'b0;
        wb_valid    <= 1'b1;
      end
      if ((state_q == WB) && !wb_valid) begin
        wb_valid <= 1'b1;
      end
      if (wb_fire) begin
        wb_valid <= 1'b0;
        alu_ctrl <= FOP_NONE;
      end
    end
  end

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Self-checking bench for fpu_issue_ctrl: a behavioural FP ALU drives the
// result port, and a per-op reference computes legality, latency, result and
// overflow straight from the op-class rules using real arithmetic.
// Honours FALU_DIV_EN the same way the design does.
module tb_fpu_issue_ctrl;

  localparam int FLEN     = 32;
  localparam int REG_ADDR = 5;
  localparam int ALU_LAT  = 1;
  localparam int DIV_LAT  = 16;
`ifdef FALU_DIV_EN
  localparam bit DIV_ON = 1'b1;
`else
  localparam bit DIV_ON = 1'b0;
`endif

  logic                CLK = 1'b0;
  logic                rst, flush, in_valid, in_ready;
  logic [2:0]          in_ctrl, in_funct3;
  logic [1:0]          in_funct7_3_2;
  logic [REG_ADDR-1:0] in_rd;
  logic [FLEN-1:0]     in_rs1, in_rs2;
  logic [FLEN-1:0]     alu_rs1, alu_rs2;
  logic [2:0]          alu_ctrl, alu_funct3;
  logic [1:0]          alu_funct7_3_2;
  logic [FLEN-1:0]     alu_result;
  logic                alu_overflow;
  logic                wb_valid, wb_ready;
  logic [REG_ADDR-1:0] wb_rd;
  logic [FLEN-1:0]     wb_data;
  logic                wb_overflow, wb_illegal, busy;

  int n_compared   = 0;
  int n_mismatched = 0;
  logic [31:0] last_wb_data;
  logic        last_wb_ovf;

  always #5 CLK = ~CLK;

  fpu_issue_ctrl #(.FLEN(FLEN), .REG_ADDR(REG_ADDR), .ALU_LAT(ALU_LAT), .DIV_LAT(DIV_LAT)) dut (
    .CLK(CLK), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_funct3(in_funct3), .in_funct7_3_2(in_funct7_3_2),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .alu_rs1(alu_rs1), .alu_rs2(alu_rs2), .alu_ctrl(alu_ctrl), .alu_funct3(alu_funct3),
    .alu_funct7_3_2(alu_funct7_3_2), .alu_result(alu_result), .alu_overflow(alu_overflow),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
    .wb_overflow(wb_overflow), .wb_illegal(wb_illegal), .busy(busy)
  );

  function automatic real f2r(input logic [31:0] b);
    real v;
    int  e;
    if (b[30:23] == 8'd0) return 0.0;
    v = 1.0 + real'(b[22:0]) / 8388608.0;
    e = int'(b[30:23]) - 127;
    while (e > 0) begin v = v * 2.0; e--; end
    while (e < 0) begin v = v / 2.0; e++; end
    return b[31] ? -v : v;
  endfunction

  function automatic logic [31:0] r2f(input real r);
    real    a;
    int     e;
    longint m;
    logic   s;
    if (r == 0.0) return 32'h0;
    s = (r < 0.0);
    a = s ? -r : r;
    e = 127;
    while (a >= 2.0) begin a = a / 2.0; e++; end
    while (a < 1.0)  begin a = a * 2.0; e--; end
    m = longint'((a - 1.0) * 8388608.0);
    if (m >= 64'sd8388608) begin m = 0; e++; end
    if (e >= 255) return {s, 8'hFF, 23'h0};
    if (e <= 0)   return {s, 31'h0};
    return {s, 8'(e), 23'(m)};
  endfunction

  function automatic logic [31:0] fp_op(input logic [2:0] c, input logic [1:0] f7,
                                        input logic [31:0] a, input logic [31:0] b);
    case (c)
      3'd0:    return r2f(f7[0] ? f2r(a) - f2r(b) : f2r(a) + f2r(b));
      3'd1:    return r2f(f2r(a) * f2r(b));
      3'd2:    return r2f(f2r(a) / f2r(b));
      3'd3:    return (f2r(a) < f2r(b)) ? 32'd1 : 32'd0;
      3'd4:    return $rtoi(f2r(a));
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  // Raw ALU flag: the product magnitude reaching 2^128, whatever the op class.
  function automatic logic fp_ovf(input logic [31:0] a, input logic [31:0] b);
    real p;
    p = f2r(a) * f2r(b);
    if (p < 0.0) p = -p;
    return p >= 3.402823669209385e38;
  endfunction

  function automatic bit ref_legal(input logic [2:0] c);
    return (c == 3'd0) || (c == 3'd1) || (c == 3'd3) || (c == 3'd4) || ((c == 3'd2) && DIV_ON);
  endfunction

  function automatic logic [31:0] rand_operand();
    return {1'($urandom_range(0, 1)), 8'($urandom_range(110, 144)), 23'($urandom)};
  endfunction

  // Behavioural registered FP ALU fed by the held operands.
  always @(posedge CLK) begin
    alu_result   <= fp_op(alu_ctrl, alu_funct7_3_2, alu_rs1, alu_rs2);
    alu_overflow <= fp_ovf(alu_rs1, alu_rs2);
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    assert (obs === exp) else begin
      n_mismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [2:0] c, input logic [2:0] f3, input logic [1:0] f7,
                       input logic [4:0] rd, input logic [31:0] a, input logic [31:0] b);
    in_ctrl = c; in_funct3 = f3; in_funct7_3_2 = f7; in_rd = rd; in_rs1 = a; in_rs2 = b;
  endtask

  // Issues one op and follows it through to the writeback handshake, with
  // wb_ready held low for 'stall' cycles after the result appears.
  task automatic applyStimulus(input logic [2:0] c, input logic [2:0] f3, input logic [1:0] f7,
                               input logic [4:0] rd, input logic [31:0] a, input logic [31:0] b,
                               input int stall);
    bit          legal;
    int          lat;
    logic [31:0] exp_data;
    logic        exp_ovf;
    logic [2:0]  exp_ctrl;
    legal    = ref_legal(c);
    lat      = legal ? (((c == 3'd2) ? DIV_LAT : ALU_LAT) + 1) : 1;
    exp_data = legal ? fp_op(c, f7, a, b) : 32'h0;
    exp_ovf  = legal && ((c == 3'd1) || (c == 3'd2)) && fp_ovf(a, b);
    exp_ctrl = legal ? c : 3'b111;
    checkOutput("in_ready_idle", 32'(in_ready), 32'd1);
    drive(c, f3, f7, rd, a, b);
    in_valid = 1'b1;
    wb_ready = (stall == 0);
    tick();
    checkOutput("alu_ctrl_accept", 32'(alu_ctrl), 32'(exp_ctrl));
    if (legal) begin
      checkOutput("alu_rs1_accept", alu_rs1, a);
      checkOutput("alu_rs2_accept", alu_rs2, b);
      checkOutput("alu_funct3_accept", 32'(alu_funct3), 32'(f3));
    end
    drive(3'd0, 3'd0, 2'd0, rd ^ 5'd1, ~a, ~b);
    for (int k = 1; k < lat; k++) begin
      tick();
      checkOutput("wb_valid_early", 32'(wb_valid), 32'd0);
      checkOutput("alu_ctrl_held", 32'(alu_ctrl), 32'(exp_ctrl));
      checkOutput("alu_rs1_held", legal ? alu_rs1 : a, a);
      checkOutput("in_ready_exec", 32'(in_ready), 32'd0);
    end
    tick();
    in_valid = 1'b0;
    checkOutput("wb_valid_on_time", 32'(wb_valid), 32'd1);
    checkOutput("wb_data", wb_data, exp_data);
    checkOutput("wb_rd", 32'(wb_rd), 32'(rd));
    checkOutput("wb_overflow", 32'(wb_overflow), 32'(exp_ovf));
    checkOutput("wb_illegal", 32'(wb_illegal), 32'(!legal));
    last_wb_data = wb_data;
    last_wb_ovf  = wb_overflow;
    for (int s = 0; s < stall; s++) begin
      tick();
      checkOutput("stall_wb_valid", 32'(wb_valid), 32'd1);
      checkOutput("stall_wb_data", wb_data, exp_data);
      checkOutput("stall_wb_rd", 32'(wb_rd), 32'(rd));
      checkOutput("stall_busy", 32'(busy), 32'd1);
      checkOutput("stall_in_ready", 32'(in_ready), 32'd0);
    end
    wb_ready = 1'b1;
    tick();
    checkOutput("done_wb_valid", 32'(wb_valid), 32'd0);
    checkOutput("done_busy", 32'(busy), 32'd0);
    checkOutput("done_alu_ctrl", 32'(alu_ctrl), 32'd7);
    checkOutput("done_in_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; wb_ready = 1'b0;
    drive(3'd0, 3'd0, 2'd0, 5'd0, 32'h0, 32'h0);
    tick(); tick();
    checkOutput("reset_alu_ctrl", 32'(alu_ctrl), 32'd7);
    checkOutput("reset_wb_valid", 32'(wb_valid), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_wb_data", wb_data, 32'h0);
    rst = 1'b0;
    tick();

    $display("[TB] directed add, stall, overflow, illegal");
    applyStimulus(3'd0, 3'd0, 2'b00, 5'd5, 32'h3F80_0000, 32'h4000_0000, 0);
    checkOutput("add_literal", last_wb_data, 32'h4040_0000);
    applyStimulus(3'd0, 3'd0, 2'b00, 5'd5, 32'h3F80_0000, 32'h4000_0000, 4);
    applyStimulus(3'd1, 3'd0, 2'b00, 5'd9, 32'h7F00_0000, 32'h7F00_0000, 0);
    checkOutput("mul_ovf_literal", 32'(last_wb_ovf), 32'd1);
    applyStimulus(3'd3, 3'd1, 2'b00, 5'd10, 32'h7F00_0000, 32'h7F00_0000, 0);
    checkOutput("cmp_ovf_literal", 32'(last_wb_ovf), 32'd0);
    applyStimulus(3'd6, 3'd2, 2'b01, 5'd11, 32'h1234_5678, 32'h9ABC_DEF0, 1);
    applyStimulus(3'd2, 3'd0, 2'b00, 5'd12, 32'h4100_0000, 32'h4000_0000, 0);

    $display("[TB] flush in first EXEC cycle");
    drive(3'd0, 3'd0, 2'd0, 5'd13, 32'h3F80_0000, 32'h3F80_0000);
    in_valid = 1'b1; wb_ready = 1'b1;
    tick();
    in_valid = 1'b0; flush = 1'b1;
    #1;
    checkOutput("flush_in_ready", 32'(in_ready), 32'd0);
    tick();
    flush = 1'b0;
    checkOutput("flush_busy", 32'(busy), 32'd0);
    checkOutput("flush_alu_ctrl", 32'(alu_ctrl), 32'd7);
    for (int k = 0; k < 4; k++) begin
      tick();
      checkOutput("flush_no_wb", 32'(wb_valid), 32'd0);
    end

    $display("[TB] flush together with in_valid");
    flush = 1'b1; in_valid = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    checkOutput("flush_noaccept_busy", 32'(busy), 32'd0);
    checkOutput("flush_noaccept_ctrl", 32'(alu_ctrl), 32'd7);

    $display("[TB] flush in WB with wb_ready high");
    drive(3'd4, 3'd0, 2'd0, 5'd14, 32'h4120_0000, 32'h0);
    in_valid = 1'b1; wb_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    checkOutput("wbflush_pre_valid", 32'(wb_valid), 32'd1);
    flush = 1'b1; wb_ready = 1'b1;
    tick();
    flush = 1'b0;
    checkOutput("wbflush_valid", 32'(wb_valid), 32'd0);
    checkOutput("wbflush_busy", 32'(busy), 32'd0);
    tick();
    checkOutput("wbflush_stays_idle", 32'(wb_valid), 32'd0);

    $display("[TB] reset while in WB");
    drive(3'd1, 3'd5, 2'd3, 5'd15, 32'h7F00_0000, 32'h7F00_0000);
    in_valid = 1'b1; wb_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    checkOutput("rstwb_pre_ovf", 32'(wb_overflow), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("rstwb_wb_valid", 32'(wb_valid), 32'd0);
    checkOutput("rstwb_wb_overflow", 32'(wb_overflow), 32'd0);
    checkOutput("rstwb_wb_data", wb_data, 32'h0);
    checkOutput("rstwb_wb_rd", 32'(wb_rd), 32'd0);
    checkOutput("rstwb_alu_ctrl", 32'(alu_ctrl), 32'd7);
    checkOutput("rstwb_alu_rs1", alu_rs1, 32'h0);
    checkOutput("rstwb_alu_funct3", 32'(alu_funct3), 32'd0);
    checkOutput("rstwb_alu_funct7", 32'(alu_funct7_3_2), 32'd0);
    checkOutput("rstwb_busy", 32'(busy), 32'd0);

    $display("[TB] randomized ops");
    for (int i = 0; i < 24; i++) begin
      applyStimulus(3'($urandom_range(0, 7)), 3'($urandom), 2'($urandom), 5'($urandom),
                    rand_operand(), rand_operand(), int'($urandom_range(0, 2)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
